// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and defaults for the CORDIC sequencer
package cordic_pkg;

    localparam int CORDIC_ITERATIONS = 25;
    localparam int CORDIC_IDX_W      = 5;

    typedef enum logic {
        CORDIC_ROT = 1'b0,
        CORDIC_VEC = 1'b1
    } cordic_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// rtl/cordic_seq_ctrl_if.sv - command, datapath and result signals of the CORDIC sequencer
interface cordic_seq_ctrl_if
    import cordic_pkg::*;
#(
    parameter int IDX_W = CORDIC_IDX_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic             abort;
    logic             dp_load;
    logic             dp_step;
    logic [IDX_W-1:0] dp_iter;
    logic             dp_mode;
    logic             dp_sign_y;
    logic             dp_sign_z;
    logic             dp_dir;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    // slave is the sequencer; master is the command source plus datapath and consumer
    modport slave (
        input  cmd_valid, cmd_mode, abort, dp_sign_y, dp_sign_z, res_ready,
        output cmd_ready, dp_load, dp_step, dp_iter, dp_mode, dp_dir, res_valid, busy
    );

    modport master (
        output cmd_valid, cmd_mode, abort, dp_sign_y, dp_sign_z, res_ready,
        input  cmd_ready, dp_load, dp_step, dp_iter, dp_mode, dp_dir, res_valid, busy
    );

endinterface

// File: rtl/cordic_iter_cnt.sv
// rtl/cordic_iter_cnt.sv - micro-rotation index counter with terminal flag
module cordic_iter_cnt
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = CORDIC_ITERATIONS,
    parameter int IDX_W      = CORDIC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    // Terminal compare stops the count before it can wrap, even when ITERATIONS == 2**IDX_W
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - load/step/result sequencer for the iterative CORDIC datapath
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = CORDIC_ITERATIONS,
    parameter int IDX_W      = CORDIC_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    cordic_seq_ctrl_if.slave   bus
);

    ctrl_state_e      state_q, state_d;
    cordic_mode_e     mode_q, mode_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [IDX_W-1:0] cnt_idx;

    logic cmd_ready_q;
    logic dp_load_q;
    logic dp_step_q;
    logic res_valid_q;
    logic busy_q;

    cordic_iter_cnt #(
        .ITERATIONS (ITERATIONS),
        .IDX_W      (IDX_W)
    ) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .idx  (cnt_idx),
        .last (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    mode_d  = cordic_mode_e'(bus.cmd_mode);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = bus.abort ? IDLE : ITER;
            end
            ITER: begin
                // abort wins over the terminal iteration
                if (bus.abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= CORDIC_ROT;
            cmd_ready_q <= 1'b1;
            dp_load_q   <= 1'b0;
            dp_step_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cmd_ready_q <= (state_d == IDLE);
            dp_load_q   <= (state_d == LOAD);
            dp_step_q   <= (state_d == ITER);
            res_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.dp_load   = dp_load_q;
    assign bus.dp_step   = dp_step_q;
    assign bus.dp_iter   = cnt_idx;
    assign bus.dp_mode   = mode_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;

    // Rotation drives z toward zero, vectoring drives y toward zero
    assign bus.dp_dir = dp_step_q &
                        ((mode_q == CORDIC_VEC) ? bus.dp_sign_y : ~bus.dp_sign_z);

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb/tb_cordic_seq_ctrl.sv - scoreboard bench for cordic_seq_ctrl
module tb_cordic_seq_ctrl;

    localparam int N_A = 25;
    localparam int N_B = 32;
    localparam int EV_LOAD = 1;
    localparam int EV_STEP = 2;
    localparam int EV_RES  = 3;

    typedef struct {
        int cyc;
        int kind;
        int iter;
        int mode;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    cordic_seq_ctrl_if #(.IDX_W(5)) ifa ();
    cordic_seq_ctrl_if #(.IDX_W(5)) ifb ();

    cordic_seq_ctrl #(.ITERATIONS(N_A), .IDX_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    cordic_seq_ctrl #(.ITERATIONS(N_B), .IDX_W(5)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    task automatic push_ev(int sel, int c, int kind, int it, int mode);
        ev_t e;
        e.cyc = c; e.kind = kind; e.iter = it; e.mode = mode;
        if (sel == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    // Expected trace of one command: load, `cut` steps, then result held rdly+1 cycles if complete
    task automatic expect_cmd(int sel, int c, int n, int mode, int cut, int rdly);
        push_ev(sel, c + 1, EV_LOAD, 0, mode);
        for (int k = 0; k < cut; k++) push_ev(sel, c + 2 + k, EV_STEP, k, mode);
        if (cut == n)
            for (int j = 0; j <= rdly; j++) push_ev(sel, c + 2 + n + j, EV_RES, 0, mode);
    endtask

    task automatic mon(int sel, logic ld, logic st, logic rv, logic [31:0] it, logic md,
                       logic dir, logic sy, logic sz, logic rdy, logic bsy);
        ev_t e;
        int  n;
        int  kind;
        int  qs;
        n    = int'(ld) + int'(st) + int'(rv);
        kind = ld ? EV_LOAD : (st ? EV_STEP : EV_RES);
        qs   = (sel == 0) ? qa.size() : qb.size();
        chk("phase_onehot", n > 1, 0);
        chk("busy_vs_phase", bsy, n > 0);
        chk("ready_vs_busy", rdy, !bsy);
        if (!st) chk("dir_outside_iter", dir, 0);
        if (n > 0) begin
            if (qs == 0) begin
                chk("unexpected_event", kind, 0);
            end else begin
                if (sel == 0) e = qa.pop_front(); else e = qb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_kind", kind, e.kind);
                if (st && e.kind == EV_STEP) begin
                    chk("dp_iter", it, e.iter);
                    chk("dp_mode", md, e.mode);
                    chk("dp_dir", dir, (e.mode != 0) ? sy : !sz);
                end
            end
        end else if (qs > 0) begin
            e = (sel == 0) ? qa[0] : qb[0];
            if (e.cyc <= cyc) begin
                chk("missing_event", 0, e.kind);
                if (sel == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ifa.dp_load, ifa.dp_step, ifa.res_valid, 32'(ifa.dp_iter), ifa.dp_mode,
                ifa.dp_dir, ifa.dp_sign_y, ifa.dp_sign_z, ifa.cmd_ready, ifa.busy);
            mon(1, ifb.dp_load, ifb.dp_step, ifb.res_valid, 32'(ifb.dp_iter), ifb.dp_mode,
                ifb.dp_dir, ifb.dp_sign_y, ifb.dp_sign_z, ifb.cmd_ready, ifb.busy);
        end
    end

    task automatic check_reset_a();
        chk("rst_cmd_ready", ifa.cmd_ready, 1);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_dp_load", ifa.dp_load, 0);
        chk("rst_dp_step", ifa.dp_step, 0);
        chk("rst_dp_iter", 32'(ifa.dp_iter), 0);
        chk("rst_dp_mode", ifa.dp_mode, 0);
        chk("rst_res_valid", ifa.res_valid, 0);
        chk("rst_dp_dir", ifa.dp_dir, 0);
    endtask

    task automatic gap(int k);
        for (int i = 0; i < k; i++) begin
            ifa.cmd_valid = 1'b0;
            ifa.cmd_mode  = 1'($urandom);
            ifa.abort     = 1'($urandom);
            ifa.res_ready = 1'($urandom);
            ifa.dp_sign_y = 1'($urandom);
            ifa.dp_sign_z = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // abort_at / rst_at: iteration index at which abort or reset is asserted, -1 for none
    task automatic run_a(int mode, int rdly, int abort_at, bit hold, int rst_at);
        int c;
        int cut;
        int end_c;
        c   = cyc;
        cut = N_A;
        if (abort_at >= 0) cut = abort_at + 1;
        if (rst_at >= 0) cut = rst_at;
        end_c = (abort_at >= 0) ? c + 2 + abort_at :
                (rst_at >= 0)   ? c + 2 + rst_at : c + 2 + N_A + rdly;
        ifa.cmd_valid = 1'b1;
        ifa.cmd_mode  = 1'(mode);
        ifa.abort     = 1'b0;
        expect_cmd(0, c, N_A, mode, cut, rdly);
        for (int cc = c + 1; cc <= end_c; cc++) begin
            @(posedge clk); #1;
            ifa.cmd_valid = hold ? 1'b1 : 1'($urandom);
            ifa.cmd_mode  = 1'($urandom);
            ifa.dp_sign_y = ~ifa.dp_sign_y;
            ifa.dp_sign_z = 1'($urandom);
            ifa.abort     = (abort_at >= 0 && cc == c + 2 + abort_at) ? 1'b1 :
                            (cc >= c + 2 + N_A) ? 1'($urandom) : 1'b0;
            ifa.res_ready = (cc >= c + 2 + N_A + rdly) ? 1'b1 :
                            (cc < c + 2 + N_A) ? 1'($urandom) : 1'b0;
            if (rst_at >= 0 && cc == end_c) begin
                rst = 1'b1;
                #1;
                check_reset_a();
            end
        end
        @(posedge clk); #1;
        if (rst_at >= 0) begin
            check_reset_a();
            rst = 1'b0;
        end
        ifa.cmd_valid = hold;
        ifa.abort     = 1'b0;
        ifa.res_ready = 1'b0;
    endtask

    task automatic run_b();
        int c;
        c = cyc;
        ifb.cmd_valid = 1'b1;
        ifb.cmd_mode  = 1'b0;
        ifb.res_ready = 1'b1;
        expect_cmd(1, c, N_B, 0, N_B, 0);
        for (int cc = c + 1; cc <= c + 2 + N_B; cc++) begin
            @(posedge clk); #1;
            ifb.cmd_valid = 1'b0;
            ifb.cmd_mode  = 1'($urandom);
            ifb.dp_sign_y = 1'($urandom);
            ifb.dp_sign_z = 1'($urandom);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        ifa.cmd_valid = 1'b0; ifa.cmd_mode = 1'b0; ifa.abort = 1'b0; ifa.res_ready = 1'b0;
        ifa.dp_sign_y = 1'b0; ifa.dp_sign_z = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_mode = 1'b0; ifb.abort = 1'b0; ifb.res_ready = 1'b0;
        ifb.dp_sign_y = 1'b0; ifb.dp_sign_z = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_a();
        chk("rst_b_cmd_ready", ifb.cmd_ready, 1);
        rst = 1'b0;
        gap(2);

        run_b();
        gap(2);

        run_a(0, 0, -1, 1'b0, -1);
        gap(1);
        run_a(1, 0, -1, 1'b0, -1);
        run_a(0, 0, -1, 1'b0, -1);
        gap(2);

        run_a(0, 5, -1, 1'b1, -1);
        run_a(1, 0, -1, 1'b0, -1);
        gap(1);

        run_a(1, 0, 10, 1'b0, -1);
        gap(1);
        run_a(0, 0, -1, 1'b0, -1);

        repeat (8) begin
            gap($urandom_range(0, 3));
            run_a(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N_A - 1)) : -1,
                  1'b0, -1);
        end

        gap(1);
        run_a(1, 0, -1, 1'b0, 7);
        gap(4);
        run_a(0, 0, -1, 1'b0, -1);
        gap(3);

        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencer for the iterative CORDIC datapath. It accepts one command at a time through a valid/ready handshake, issues a load pulse, then issues ITERATIONS step strobes with the current iteration index (shift amount and arctan-table address). It derives the per-iteration rotation direction from the datapath sign flags and holds the result valid until the consumer accepts it. It sits between the coprocessor command interface and the x/y/z iteration registers.

## Interface
- ITERATIONS, 25, number of micro-rotations per command; must satisfy 1 ≤ ITERATIONS ≤ 2**IDX_W.
- IDX_W, 5, width of the iteration index.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_mode  in  1  0 = rotation, 1 = vectoring; sampled on accept.
- abort  in  1  cancel the command in flight.
- dp_load  out  1  one-cycle pulse: datapath loads its operands.
- dp_step  out  1  datapath performs one micro-rotation this cycle.
- dp_iter  out  IDX_W  iteration index i, used as shift amount and atan LUT address.
- dp_mode  out  1  latched mode of the command in flight.
- dp_sign_y  in  1  sign bit of the current y register.
- dp_sign_z  in  1  sign bit of the current z register.
- dp_dir  out  1  1 means d = +1 (x -= y>>i, y += x>>i, z -= atan_i); 0 means d = −1.
- res_valid  out  1  result registers hold the final value.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in LOAD, ITER and DONE.

## Operation
- States: IDLE, LOAD, ITER, DONE. All outputs except dp_dir are registered, Moore-style, and decoded from the state and counter.
- IDLE: cmd_ready=1. When cmd_valid & cmd_ready, latch cmd_mode into mode_q and go to LOAD.
- LOAD: dp_load=1 for exactly one cycle, iteration counter cleared, then go to ITER.
- ITER: dp_step=1 and dp_iter=counter. The counter increments each cycle. After the cycle with dp_iter=ITERATIONS−1, go to DONE and clear the counter to 0.
- DONE: res_valid=1, held until res_ready is high. Then go to IDLE.
- dp_dir is combinational from mode_q and the sign flags:
  - rotation: dp_dir = ~dp_sign_z
  - vectoring: dp_dir = dp_sign_y
  - It is meaningful only while dp_step=1; outside ITER it is forced to 0.
- Command stimulus:
  - cmd_valid while busy is ignored and is not queued.
  - cmd_mode is ignored outside the accept cycle.
- abort:
  - In LOAD or ITER, the next state is IDLE, the counter clears, and no res_valid is produced.
  - In IDLE or DONE, abort is ignored.
  - abort has priority over counter completion in the same cycle.
- Reset values: state IDLE, cmd_ready=1, dp_load=0, dp_step=0, dp_iter=0, dp_mode=0, res_valid=0, busy=0.
- Reset mid-operation returns to IDLE immediately and asynchronously, with no res_valid.

## Timing
- Command accepted at rising edge T:
  - dp_load is high in cycle T+1.
  - dp_step is high in cycles T+2 … T+1+ITERATIONS, with dp_iter running 0 … ITERATIONS−1.
  - res_valid first rises in cycle T+2+ITERATIONS.
- Handshake:
  - res_valid & res_ready at edge E gives cmd_ready=1 in cycle E+1.
  - The earliest next accept is at E+1.
  - Minimum command-to-command period is ITERATIONS+3 cycles.
- Counter arithmetic: IDX_W-bit unsigned. The terminal compare is against ITERATIONS−1, so the counter never wraps past the terminal value. With ITERATIONS = 2**IDX_W the terminal value is all-ones.

## Structure
- Shared package cordic_pkg holds:
  - typedef enum cordic_mode_e {CORDIC_ROT, CORDIC_VEC};
  - typedef enum ctrl_state_e {IDLE, LOAD, ITER, DONE};
  - default constants CORDIC_ITERATIONS=25 and CORDIC_IDX_W=5.
- One sub-module, cordic_iter_cnt, implements the iteration counter:
  - inputs: clr, en
  - outputs: idx, last
- The FSM, mode latch and direction logic live in cordic_seq_ctrl.

## Test plan
- Reset asserted mid-ITER (dp_iter=7) → same-cycle return to reset values; cmd_ready=1, busy=0, no res_valid afterwards.
- Rotation command accepted at cycle 0, res_ready held high → dp_load in cycle 1; dp_step in cycles 2–26 with dp_iter 0..24; res_valid in cycle 27 only; cmd_ready in cycle 28.
- res_ready held low for 5 cycles in DONE, with cmd_valid held high throughout → res_valid stays high; cmd_ready=0; no second dp_load until one cycle after res_ready rises.
- Vectoring command with dp_sign_y toggling every cycle → dp_dir equals dp_sign_y on every dp_step cycle. Repeat in rotation mode → dp_dir equals ~dp_sign_z on every dp_step cycle.
- abort asserted in the cycle where dp_iter=10 → IDLE next cycle; dp_step=0; res_valid never rises; a new command is then accepted and dp_iter restarts at 0.
- ITERATIONS=32, IDX_W=5 → dp_iter reaches 31 and res_valid follows; no extra step and no wrap to 0 while in ITER.
